// File: rtl/memory_fill_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | memory_fill_pkg : engine states and fill pattern modes.  Rev 1.0   |
// +--------------------------------------------------------------------+
package memory_fill_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fill_state_t;

  localparam logic [1:0] MODE_CONST    = 2'd0;
  localparam logic [1:0] MODE_ADDR_XOR = 2'd1;
  localparam logic [1:0] MODE_INCR     = 2'd2;

endpackage
`default_nettype wire

// File: rtl/memory_fill_engine_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | memory_fill_engine_if : single-port memory bus.  Rev 1.0           |
// +--------------------------------------------------------------------+
interface memory_fill_engine_if #(
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 32
);
  logic                  wren;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data_write;
  logic [DATA_WIDTH-1:0] data_read;

  modport master (output wren, address, data_write, input data_read);
  modport slave  (input wren, address, data_write, output data_read);
endinterface
`default_nettype wire

// File: rtl/fill_compare_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fill_compare_pipe : expected data/address delay line.  Rev 1.0     |
// +--------------------------------------------------------------------+
module fill_compare_pipe
  import memory_fill_pkg::*;
#(
  parameter int READ_LATENCY = 2,
  parameter int ADDR_WIDTH   = 18,
  parameter int DATA_WIDTH   = 32
) (
  input  wire logic                  clk,
  input  wire logic                  reset,
  input  wire logic                  flush,
  input  wire logic                  in_valid,
  input  wire logic [ADDR_WIDTH-1:0] in_addr,
  input  wire logic [DATA_WIDTH-1:0] in_data,
  output logic                       out_valid,
  output logic [ADDR_WIDTH-1:0]      out_addr,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic                       pending
);

  logic [READ_LATENCY-1:0] r_valid;
  logic [ADDR_WIDTH-1:0]   r_addr [READ_LATENCY];
  logic [DATA_WIDTH-1:0]   r_data [READ_LATENCY];
  logic [READ_LATENCY-1:0] w_early;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      r_valid[0] <= in_valid & ~flush;
      r_addr[0]  <= in_addr;
      r_data[0]  <= in_data;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_valid[i] <= r_valid[i-1] & ~flush;
        r_addr[i]  <= r_addr[i-1];
        r_data[i]  <= r_data[i-1];
      end
    end
  end

  // Entries still in flight after the one being compared this cycle.
  always_comb begin
    w_early                 = r_valid;
    w_early[READ_LATENCY-1] = 1'b0;
  end

  assign pending   = |w_early;
  assign out_valid = r_valid[READ_LATENCY-1];
  assign out_addr  = r_addr[READ_LATENCY-1];
  assign out_data  = r_data[READ_LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/memory_fill_engine.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | memory_fill_engine : pattern fill / read-back verify.  Rev 1.0     |
// +--------------------------------------------------------------------+
module memory_fill_engine
  import memory_fill_pkg::*;
#(
  parameter int ADDR_WIDTH   = 18,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 2
) (
  input  wire logic                  clk,
  input  wire logic                  reset,
  input  wire logic                  enable,
  input  wire logic                  pause,
  input  wire logic                  verify,
  input  wire logic [1:0]            mode,
  input  wire logic [DATA_WIDTH-1:0] pattern,
  input  wire logic [ADDR_WIDTH-1:0] start_address,
  input  wire logic [ADDR_WIDTH-1:0] end_address,
  memory_fill_engine_if.master       mem,
  output logic                       done,
  output logic                       error,
  output logic [15:0]                error_count,
  output logic [ADDR_WIDTH-1:0]      first_error_address
);

  fill_state_t           r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_start, r_end, r_cur, r_address, r_first_err;
  logic [ADDR_WIDTH-1:0] w_index;
  logic [1:0]            r_mode;
  logic                  r_verify;
  logic [DATA_WIDTH-1:0] r_pattern, r_data_write, w_expected;
  logic                  r_wren, r_done, r_error;
  logic [15:0]           r_err_cnt;
  logic                  w_issue, w_pending, w_cmp_valid, w_miss;
  logic [ADDR_WIDTH-1:0] w_cmp_addr;
  logic [DATA_WIDTH-1:0] w_cmp_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    if (!enable) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:  w_state_nxt = RUN;
        RUN: begin
          if (r_end < r_start) begin
            w_state_nxt = DONE;
          end else if (!pause) begin
            w_issue = 1'b1;
            // The end address is detected before incrementing, so all-ones never wraps.
            if (r_cur == r_end) w_state_nxt = r_verify ? DRAIN : DONE;
          end
        end
        DRAIN: if (!w_pending) w_state_nxt = DONE;
        DONE:  w_state_nxt = DONE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    w_index = r_cur - r_start;
    case (r_mode)
      MODE_ADDR_XOR: w_expected = r_pattern ^ DATA_WIDTH'(r_cur);
      MODE_INCR:     w_expected = r_pattern + DATA_WIDTH'(w_index);
      default:       w_expected = r_pattern;
    endcase
  end

  fill_compare_pipe #(
    .READ_LATENCY (READ_LATENCY),
    .ADDR_WIDTH   (ADDR_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH)
  ) u_pipe (
    .clk       (clk),
    .reset     (reset),
    .flush     (~enable),
    .in_valid  (w_issue & r_verify),
    .in_addr   (r_cur),
    .in_data   (w_expected),
    .out_valid (w_cmp_valid),
    .out_addr  (w_cmp_addr),
    .out_data  (w_cmp_data),
    .pending   (w_pending)
  );

  assign w_miss = w_cmp_valid && (w_cmp_data != mem.data_read);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_start      <= '0;
      r_end        <= '0;
      r_cur        <= '0;
      r_mode       <= MODE_CONST;
      r_verify     <= 1'b0;
      r_pattern    <= '0;
      r_wren       <= 1'b0;
      r_address    <= '0;
      r_data_write <= '0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_err_cnt    <= '0;
      r_first_err  <= '0;
    end else if (!enable) begin
      r_wren       <= 1'b0;
      r_address    <= '0;
      r_data_write <= '0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_err_cnt    <= '0;
      r_first_err  <= '0;
    end else begin
      if (r_state == IDLE) begin
        r_start   <= start_address;
        r_end     <= end_address;
        r_cur     <= start_address;
        r_mode    <= mode;
        r_verify  <= verify;
        r_pattern <= pattern;
      end
      r_wren <= w_issue & ~r_verify;
      if (w_issue) begin
        r_address    <= r_cur;
        r_data_write <= r_verify ? '0 : w_expected;
        r_cur        <= r_cur + ADDR_WIDTH'(1);
      end
      r_done <= (w_state_nxt == DONE);
      if (w_miss) begin
        r_error <= 1'b1;
        if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
        if (!r_error) r_first_err <= w_cmp_addr;
      end
    end
  end

  assign mem.wren            = r_wren;
  assign mem.address         = r_address;
  assign mem.data_write      = r_data_write;
  assign done                = r_done;
  assign error               = r_error;
  assign error_count         = r_err_cnt;
  assign first_error_address = r_first_err;

endmodule
`default_nettype wire

// File: tb/tb_memory_fill_engine.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_memory_fill_engine : directed bench with memory and pass model. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_memory_fill_engine;

  typedef struct packed {
    logic [17:0] a;
    logic [31:0] d;
  } acc_t;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        pause;
  logic        verify;
  logic [1:0]  mode;
  logic [31:0] pattern;
  logic [17:0] start_address;
  logic [17:0] end_address;
  logic        done;
  logic        error;
  logic [15:0] error_count;
  logic [17:0] first_error_address;

  int   n_vec = 0;
  int   n_err = 0;
  bit   fault = 0;
  bit   vmon  = 0;
  acc_t exp_q[$];
  logic [31:0] mem_arr [0:63];

  memory_fill_engine_if #(.ADDR_WIDTH(18), .DATA_WIDTH(32)) mem_if ();

  memory_fill_engine #(.ADDR_WIDTH(18), .DATA_WIDTH(32), .READ_LATENCY(2)) dut (
    .clk                 (clk),
    .reset               (reset),
    .enable              (enable),
    .pause               (pause),
    .verify              (verify),
    .mode                (mode),
    .pattern             (pattern),
    .start_address       (start_address),
    .end_address         (end_address),
    .mem                 (mem_if),
    .done                (done),
    .error               (error),
    .error_count         (error_count),
    .first_error_address (first_error_address)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two-cycle read memory: address registered one edge, data the next.
  always @(posedge clk) begin
    if (mem_if.wren) mem_arr[mem_if.address[5:0]] <= mem_if.data_write;
    mem_if.data_read <= fault ? ((mem_if.address == 18'd5) ? 32'd0 : {14'd0, mem_if.address})
                              : mem_arr[mem_if.address[5:0]];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input logic [1:0] m, input logic [31:0] p,
                                             input int a, input int s);
    case (m)
      2'd1:    return p ^ a;
      2'd2:    return p + (a - s);
      default: return p;
    endcase
  endfunction

  function automatic logic [31:0] model_mem(input int a);
    if (fault) return (a == 5) ? 32'd0 : a;
    return mem_arr[a[5:0]];
  endfunction

  task automatic load_writes(input logic [1:0] m, input logic [31:0] p, input int s, input int e);
    for (int a = s; a <= e; a++) exp_q.push_back(acc_t'{a[17:0], model_word(m, p, a, s)});
  endtask

  task automatic model_verify(input logic [1:0] m, input logic [31:0] p, input int s, input int e,
                              output int cnt, output int first);
    cnt = 0;
    first = 0;
    for (int a = s; a <= e; a++) begin
      if (model_mem(a) != model_word(m, p, a, s)) begin
        if (cnt == 0) first = a;
        cnt++;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (vmon) begin
        chk("verify_wren", mem_if.wren, 0);
        chk("verify_wdata", mem_if.data_write, 0);
      end else if (mem_if.wren) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", mem_if.wren, 0);
        end else begin
          acc_t e;
          e = exp_q.pop_front();
          chk("write_addr", mem_if.address, e.a);
          chk("write_data", mem_if.data_write, e.d);
        end
      end
    end
  end

  task automatic start_pass(input bit v, input logic [1:0] m, input logic [31:0] p,
                            input logic [17:0] s, input logic [17:0] e);
    @(negedge clk);
    verify = v; vmon = v; mode = m; pattern = p;
    start_address = s; end_address = e; enable = 1'b1;
  endtask

  task automatic wait_done(input int pause_at, input int pause_len, output int cyc);
    cyc = 0;
    while (cyc < 300) begin
      pause = (cyc >= pause_at) && (cyc < pause_at + pause_len);
      @(negedge clk);
      cyc++;
      if (done) break;
    end
    pause = 1'b0;
    chk("done_reached", done, 1);
  endtask

  task automatic finish_pass(input int ecnt, input int efirst);
    @(negedge clk);
    chk("done_hold", done, 1);
    chk("done_wren", mem_if.wren, 0);
    chk("result_error", error, (ecnt != 0));
    chk("result_count", error_count, ecnt);
    if (ecnt != 0) chk("result_first", first_error_address, efirst);
    chk("writes_left", exp_q.size(), 0);
    enable = 1'b0;
    @(negedge clk);
    chk("idle_done", done, 0);
    chk("idle_count", error_count, 0);
  endtask

  int cyc, ecnt, efirst;

  initial begin
    reset = 1'b1; enable = 1'b0; pause = 1'b0; verify = 1'b0; mode = 2'd0;
    pattern = '0; start_address = '0; end_address = '0;
    #23;
    chk("rst_wren", mem_if.wren, 0);
    chk("rst_addr", mem_if.address, 0);
    chk("rst_wdata", mem_if.data_write, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_count", error_count, 0);
    chk("rst_first", first_error_address, 0);
    @(negedge clk);
    reset = 1'b0;

    // Constant fill 0..3, literal expectations
    for (int a = 0; a < 4; a++) exp_q.push_back(acc_t'{a[17:0], 32'h77553311});
    start_pass(0, 2'd0, 32'h77553311, 18'd0, 18'd3);
    wait_done(0, 0, cyc);
    chk("const_cycles", cyc, 5);
    finish_pass(0, 0);

    // Incrementing fill wrapping through zero, literal expectations
    exp_q.push_back(acc_t'{18'd10, 32'hFFFFFFFE});
    exp_q.push_back(acc_t'{18'd11, 32'hFFFFFFFF});
    exp_q.push_back(acc_t'{18'd12, 32'h00000000});
    start_pass(0, 2'd2, 32'hFFFFFFFE, 18'd10, 18'd12);
    wait_done(0, 0, cyc);
    chk("incr_cycles", cyc, 4);
    finish_pass(0, 0);

    // Address-XOR fill, then clean read-back
    load_writes(2'd1, 32'hA5A50000, 20, 27);
    start_pass(0, 2'd1, 32'hA5A50000, 18'd20, 18'd27);
    wait_done(0, 0, cyc);
    chk("xor_cycles", cyc, 9);
    finish_pass(0, 0);
    model_verify(2'd1, 32'hA5A50000, 20, 27, ecnt, efirst);
    start_pass(1, 2'd1, 32'hA5A50000, 18'd20, 18'd27);
    wait_done(0, 0, cyc);
    chk("xor_verify_cycles", cyc, 1 + 8 + 2);
    finish_pass(ecnt, efirst);

    // Mode 3 behaves as constant
    load_writes(2'd3, 32'h12345678, 30, 31);
    start_pass(0, 2'd3, 32'h12345678, 18'd30, 18'd31);
    wait_done(0, 0, cyc);
    chk("mode3_cycles", cyc, 3);
    finish_pass(0, 0);

    // Ten writes with a three-cycle pause
    load_writes(2'd2, 32'd100, 0, 9);
    start_pass(0, 2'd2, 32'd100, 18'd0, 18'd9);
    wait_done(4, 3, cyc);
    chk("pause_write_cycles", cyc, 14);
    finish_pass(0, 0);

    // Paused read-back must not disturb in-flight reads
    model_verify(2'd2, 32'd100, 0, 9, ecnt, efirst);
    start_pass(1, 2'd2, 32'd100, 18'd0, 18'd9);
    wait_done(5, 2, cyc);
    chk("pause_verify_cycles", cyc, 1 + 10 + 2 + 2);
    finish_pass(ecnt, efirst);

    // Wrong seed: every word mismatches
    model_verify(2'd2, 32'd101, 0, 9, ecnt, efirst);
    start_pass(1, 2'd2, 32'd101, 18'd0, 18'd9);
    wait_done(0, 0, cyc);
    finish_pass(ecnt, efirst);

    // Faulty memory: address 5 reads as zero
    fault = 1'b1;
    model_verify(2'd1, 32'd0, 0, 7, ecnt, efirst);
    start_pass(1, 2'd1, 32'd0, 18'd0, 18'd7);
    wait_done(0, 0, cyc);
    chk("fault_cycles", cyc, 11);
    chk("fault_error_lit", error, 1);
    chk("fault_count_lit", error_count, 1);
    chk("fault_first_lit", first_error_address, 5);
    finish_pass(ecnt, efirst);

    // Enable dropped mid-verify
    start_pass(1, 2'd1, 32'd0, 18'd0, 18'd7);
    repeat (10) @(negedge clk);
    chk("drop_err_before", error, 1);
    enable = 1'b0;
    @(negedge clk);
    chk("drop_done", done, 0);
    chk("drop_wren", mem_if.wren, 0);
    chk("drop_error", error, 0);
    chk("drop_count", error_count, 0);
    chk("drop_first", first_error_address, 0);
    fault = 1'b0;

    // Empty range
    start_pass(0, 2'd0, 32'h1, 18'd5, 18'd4);
    wait_done(0, 0, cyc);
    chk("empty_cycles", cyc, 2);
    finish_pass(0, 0);

    // Asynchronous reset mid-pass with enable held, then fresh pass
    load_writes(2'd0, 32'hDEADBEEF, 40, 47);
    start_pass(0, 2'd0, 32'hDEADBEEF, 18'd40, 18'd47);
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_wren", mem_if.wren, 0);
    chk("arst_addr", mem_if.address, 0);
    chk("arst_wdata", mem_if.data_write, 0);
    chk("arst_done", done, 0);
    exp_q.delete();
    load_writes(2'd0, 32'hDEADBEEF, 40, 47);
    @(negedge clk);
    reset = 1'b0;
    wait_done(0, 0, cyc);
    chk("rerun_cycles", cyc, 9);
    finish_pass(0, 0);

    // Top of address space, no wrap
    load_writes(2'd1, 32'h0, 18'h3FFFE, 18'h3FFFF);
    start_pass(0, 2'd1, 32'h0, 18'h3FFFE, 18'h3FFFF);
    wait_done(0, 0, cyc);
    chk("top_cycles", cyc, 3);
    finish_pass(0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
